lpf_target_loader: RTL and testbench

Producer-side front end of the silent low-pass filter stage. It streams one frame of per-transducer duty/phase targets out of the modulation BRAM into parallel target arrays, latches the step size, and issues the single-cycle UPDATE strobe that the LPF accepts only while idle. It tracks the LPF's busy/valid handshake so it never strobes UPDATE into a busy filter, and it queues one pending frame request while a load or handoff is in progress.

---
 rtl/lpf_target_loader_if.sv | 39 +++
 rtl/lpf_target_loader.sv | 133 +++++++++++++
 tb/tb_lpf_target_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lpf_target_loader_if.sv
// Bus bundle between the target loader, the modulation BRAM and the silent LPF.
// The loader drives the BRAM address and the LPF-facing targets; the LPF reports completion back.
interface lpf_target_loader_if #(
    parameter int TRANS_NUM = 249,
    parameter int WIDTH     = 8
);
    localparam int AW = $clog2(TRANS_NUM);

    logic [AW-1:0]      BRAM_ADDR;
    logic [2*WIDTH-1:0] BRAM_DATA;
    // Handshake: UPDATE is a one-cycle strobe, issued only while the LPF is idle; the LPF
    // samples STEP/DUTY/PHASE on that edge, drops OUT_VALID one cycle later, and raises
    // OUT_VALID again once its pass is finished.
    logic               LPF_OUT_VALID;
    logic               UPDATE;
    logic [WIDTH-1:0]   STEP;
    logic [WIDTH-1:0]   DUTY  [0:TRANS_NUM-1];
    logic [WIDTH-1:0]   PHASE [0:TRANS_NUM-1];

    modport master (
        output BRAM_ADDR,
        input  BRAM_DATA,
        input  LPF_OUT_VALID,
        output UPDATE,
        output STEP,
        output DUTY,
        output PHASE
    );

    modport slave (
        input  BRAM_ADDR,
        output BRAM_DATA,
        output LPF_OUT_VALID,
        input  UPDATE,
        input  STEP,
        input  DUTY,
        input  PHASE
    );
endinterface

// File: rtl/lpf_target_loader.sv
// Streams one frame of duty/phase targets from BRAM into parallel arrays and hands them
// to the LPF with a single UPDATE strobe, never while the filter is still busy.
module lpf_target_loader #(
    parameter int TRANS_NUM    = 249,
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] STEP_IN,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic [1:0]       DBG_STATE,
    lpf_target_loader_if.master bus
);
    localparam int AW = $clog2(TRANS_NUM);
    localparam logic [AW-1:0] LAST = AW'(TRANS_NUM - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] step_q;
    logic [AW-1:0]    addr_q;
    logic             iss_q;
    logic             vld_q [READ_LATENCY];
    logic [AW-1:0]    idx_q [READ_LATENCY];
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             lpf_busy_q;
    logic [1:0]       ack_q;
    logic             update_q;
    logic [WIDTH-1:0] duty_q  [0:TRANS_NUM-1];
    logic [WIDTH-1:0] phase_q [0:TRANS_NUM-1];

    logic start_now, cap, cap_last, fire;

    always_comb begin
        start_now = (state_q == IDLE) && (START || pending_q);
        cap       = (state_q == READ) && vld_q[READ_LATENCY-1];
        cap_last  = cap && (idx_q[READ_LATENCY-1] == LAST);
        // UPDATE is registered, so the decision is made one edge ahead of the strobe.
        fire      = !lpf_busy_q && (cap_last || ((state_q == HANDOFF) && !update_q));
        pending_d = pending_q;
        overrun_d = 1'b0;
        if (start_now) begin
            pending_d = START && pending_q;
        end else if (START) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            step_q     <= '0;
            addr_q     <= '0;
            iss_q      <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            lpf_busy_q <= 1'b0;
            ack_q      <= 2'd0;
            update_q   <= 1'b0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_q[k] <= 1'b0;
                idx_q[k] <= '0;
            end
            for (int i = 0; i < TRANS_NUM; i++) begin
                duty_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            update_q  <= fire;

            vld_q[0] <= (state_q == READ) && iss_q;
            idx_q[0] <= addr_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end

            if (cap) begin
                duty_q[idx_q[READ_LATENCY-1]]  <= bus.BRAM_DATA[2*WIDTH-1:WIDTH];
                phase_q[idx_q[READ_LATENCY-1]] <= bus.BRAM_DATA[WIDTH-1:0];
            end

            // Ignore the stale OUT_VALID the LPF still shows just after accepting UPDATE.
            if (fire)               ack_q <= 2'd2;
            else if (ack_q != 2'd0) ack_q <= ack_q - 2'd1;

            if (fire)                                        lpf_busy_q <= 1'b1;
            else if ((ack_q == 2'd0) && bus.LPF_OUT_VALID)   lpf_busy_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_now) begin
                        step_q  <= STEP_IN;
                        addr_q  <= '0;
                        iss_q   <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (iss_q) begin
                        if (addr_q == LAST) iss_q  <= 1'b0;
                        else                addr_q <= addr_q + 1'b1;
                    end
                    if (cap_last) state_q <= HANDOFF;
                end
                HANDOFF: begin
                    if (update_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.BRAM_ADDR = addr_q;
    assign bus.UPDATE    = update_q;
    assign bus.STEP      = step_q;
    assign bus.DUTY      = duty_q;
    assign bus.PHASE     = phase_q;
    assign BUSY          = (state_q != IDLE);
    assign OVERRUN       = overrun_q;
    assign DBG_STATE     = state_q;
endmodule

// File: tb/tb_lpf_target_loader.sv
// Directed bench for lpf_target_loader: a frame table plus hand-written sequences for
// reset, blocked handoff, pending/overrun and step latching.
module tb_lpf_target_loader;
    localparam int TN = 249;
    localparam int W  = 8;
    localparam int RL = 2;

    logic         CLK     = 1'b0;
    logic         RST_N   = 1'b1;
    logic         START   = 1'b0;
    logic [W-1:0] STEP_IN = '0;
    logic         BUSY;
    logic         OVERRUN;
    logic [1:0]   DBG_STATE;

    logic [7:0]   seed = 8'h00;
    logic [15:0]  bram_r1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0] step_in;
        logic [7:0] seed;
        int         idx;
        logic [7:0] exp_duty;
        logic [7:0] exp_phase;
        int         exp_upd;
    } vec_t;

    vec_t vecs[5];

    lpf_target_loader_if #(.TRANS_NUM(TN), .WIDTH(W)) lif();

    lpf_target_loader #(.TRANS_NUM(TN), .WIDTH(W), .READ_LATENCY(RL)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .STEP_IN   (STEP_IN),
        .BUSY      (BUSY),
        .OVERRUN   (OVERRUN),
        .DBG_STATE (DBG_STATE),
        .bus       (lif)
    );

    always #5 CLK = ~CLK;

    // BRAM with two registered stages: duty = addr + seed, phase = 0xFF - addr - seed.
    function automatic logic [15:0] bram_word(input logic [7:0] a, input logic [7:0] s);
        logic [7:0] d;
        logic [7:0] p;
        d = a + s;
        p = 8'hFF - a - s;
        return {d, p};
    endfunction

    always @(posedge CLK) begin
        bram_r1       <= bram_word(lif.BRAM_ADDR, seed);
        lif.BRAM_DATA <= bram_r1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the caller just after edge 0 (START sampled), i.e. inside cycle 1.
    task automatic start_edge0(input logic [7:0] step);
        @(posedge CLK);
        #1;
        START   = 1'b1;
        STEP_IN = step;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    initial begin
        int upd_k;
        int busy_cnt;
        int n_upd;
        int n_ovr;
        int ovr_at;
        int first_upd;
        int second_upd;
        logic [7:0] stp;
        logic       busy_after;
        logic       found;

        vecs[0] = '{8'h10, 8'h00,   5, 8'h05, 8'hFA, 252};
        vecs[1] = '{8'hA5, 8'h00, 248, 8'hF8, 8'h07, 252};
        vecs[2] = '{8'h01, 8'h20,   0, 8'h20, 8'hDF, 252};
        vecs[3] = '{8'hFF, 8'h20, 240, 8'h10, 8'hEF, 252};
        vecs[4] = '{8'h00, 8'h00, 128, 8'h80, 8'h7F, 252};

        lif.LPF_OUT_VALID = 1'b1;

        // Reset state
        #2 RST_N = 1'b0;
        #1;
        check("rst_busy",    BUSY, 0);
        check("rst_update",  lif.UPDATE, 0);
        check("rst_overrun", OVERRUN, 0);
        check("rst_step",    lif.STEP, 0);
        check("rst_addr",    lif.BRAM_ADDR, 0);
        check("rst_duty0",   lif.DUTY[0], 0);
        check("rst_phase248", lif.PHASE[248], 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Table of single frames with the LPF idle; STEP_IN is disturbed mid-READ.
        foreach (vecs[v]) begin
            seed  = vecs[v].seed;
            upd_k = -1;
            stp   = '0;
            busy_after = 1'b1;
            start_edge0(vecs[v].step_in);
            for (int k = 1; k <= 400; k++) begin
                @(negedge CLK);
                if (k == 50) STEP_IN = ~vecs[v].step_in;
                if (k == 2) check("vec_addr_c2", lif.BRAM_ADDR, 1);
                if (lif.UPDATE) begin
                    upd_k = k;
                    stp   = lif.STEP;
                    @(negedge CLK);
                    busy_after = BUSY;
                    break;
                end
            end
            check("vec_upd_cycle", upd_k, vecs[v].exp_upd);
            check("vec_step",      stp, vecs[v].step_in);
            check("vec_busy_fall", busy_after, 0);
            check("vec_duty",      lif.DUTY[vecs[v].idx], vecs[v].exp_duty);
            check("vec_phase",     lif.PHASE[vecs[v].idx], vecs[v].exp_phase);
            repeat (3) @(negedge CLK);
        end

        // Reset mid-READ discards the frame.
        seed = 8'h00;
        start_edge0(8'h33);
        for (int k = 1; k <= 100; k++) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("midrst_duty5",  lif.DUTY[5], 0);
        check("midrst_phase5", lif.PHASE[5], 0);
        check("midrst_step",   lif.STEP, 0);
        check("midrst_addr",   lif.BRAM_ADDR, 0);
        @(negedge CLK);
        check("midrst_busy",   BUSY, 0);
        RST_N = 1'b1;
        n_upd    = 0;
        busy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (lif.UPDATE) n_upd++;
            if (BUSY) busy_cnt++;
        end
        check("midrst_no_update", n_upd, 0);
        check("midrst_no_busy",   busy_cnt, 0);

        // LPF busy: first UPDATE, OUT_VALID held low, second frame waits in HANDOFF.
        seed  = 8'h00;
        found = 1'b0;
        start_edge0(8'h10);
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (lif.UPDATE) begin
                found = 1'b1;
                lif.LPF_OUT_VALID = 1'b0;
                break;
            end
        end
        check("busy_first_update", found, 1);
        repeat (3) @(negedge CLK);
        seed  = 8'h20;
        upd_k = -1;
        start_edge0(8'h44);
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (DBG_STATE == 2'd2) begin
                upd_k = k;
                break;
            end
        end
        check("busy_handoff_cycle", upd_k, 252);
        check("busy_duty7",  lif.DUTY[7], 8'h27);
        check("busy_phase7", lif.PHASE[7], 8'hD8);
        n_upd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (lif.UPDATE) n_upd++;
        end
        check("busy_held_no_update", n_upd, 0);
        check("busy_held_busy", BUSY, 1);
        lif.LPF_OUT_VALID = 1'b1;   // cycle T
        @(negedge CLK);
        check("busy_upd_T1", lif.UPDATE, 0);
        @(negedge CLK);
        check("busy_upd_T2", lif.UPDATE, 1);
        check("busy_step",   lif.STEP, 8'h44);
        @(negedge CLK);
        check("busy_update_one_cycle", lif.UPDATE, 0);
        check("busy_released", BUSY, 0);
        repeat (4) @(negedge CLK);

        // Pending and overrun with OUT_VALID stuck high: STARTs at edges 0, 10, 20.
        seed = 8'h00;
        exp_q.delete();
        exp_q.push_back(252);
        exp_q.push_back(505);
        n_upd = 0; n_ovr = 0; ovr_at = 0; busy_cnt = 0;
        first_upd = 0; second_upd = 0;
        start_edge0(8'h5A);
        for (int k = 1; k <= 560; k++) begin
            @(negedge CLK);
            START = (k == 10) || (k == 20);
            if (lif.UPDATE) begin
                n_upd++;
                if (n_upd == 1) first_upd = k;
                if (n_upd == 2) second_upd = k;
                if (exp_q.size() > 0) check("pend_upd_cycle", k, exp_q.pop_front());
            end
            if (OVERRUN) begin
                n_ovr++;
                ovr_at = k;
            end
            if (k <= 505 && !BUSY) busy_cnt++;
        end
        START = 1'b0;
        check("pend_update_count",  n_upd, 2);
        check("pend_overrun_count", n_ovr, 1);
        check("pend_overrun_cycle", ovr_at, 21);
        check("pend_idle_gap",      busy_cnt, 1);
        check("pend_spacing_ge3",   (second_upd - first_upd) >= 3, 1);
        check("pend_queue_empty",   exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
